// File: rtl/pwm_seq_pkg.sv
// Shared types for the PWM duty-cycle sequencer.
// Pure type/constant package: no logic, no latency, no flow control.
package pwm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN
  } state_e;

endpackage

// File: rtl/pwm_seq_table.sv
// Compare-value register file: sync write, async read, cleared by rst.
// Write lands on the clock edge; read is combinational; no backpressure (caller gates we_i).
module pwm_seq_table #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pwm_sequencer.sv
// Steps a PWM generator's compare value through a table, one entry per (repeat+1) periods.
// New value registered the edge after a period_start rising edge; table writes stall outside IDLE.
module pwm_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8,
  parameter int DEPTH         = 8,
  parameter int REPEAT_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [COUNTER_WIDTH-1:0] wr_data_i,
  input  logic                     enable_i,
  input  logic [$clog2(DEPTH)-1:0] seq_len_i,
  input  logic [REPEAT_WIDTH-1:0]  repeat_i,
  input  logic                     period_start_i,
  output logic [COUNTER_WIDTH-1:0] cmp_value_o,
  output logic                     pwm_set_o,
  output logic [$clog2(DEPTH)-1:0] step_idx_o,
  output logic                     wrap_o
);

  localparam int AW = $clog2(DEPTH);

  state_e                   state_q;
  logic [AW-1:0]            idx_q;
  logic [AW-1:0]            idx_d;
  logic [AW-1:0]            seq_len_sh_q;
  logic [AW-1:0]            rd_addr;
  logic [REPEAT_WIDTH-1:0]  rep_cnt_q;
  logic [REPEAT_WIDTH-1:0]  repeat_sh_q;
  logic                     ps_q;
  logic                     pwm_set_q;
  logic                     wrap_q;
  logic [COUNTER_WIDTH-1:0] cmp_q;
  logic [COUNTER_WIDTH-1:0] rd_data;
  logic                     wr_en;
  logic                     boundary;

  assign wr_ready_o = (state_q == IDLE);
  assign wr_en      = wr_valid_i & wr_ready_o;
  assign boundary   = period_start_i & ~ps_q;
  assign idx_d      = (idx_q == seq_len_sh_q) ? '0 : idx_q + AW'(1);
  // START always fetches entry 0; RUN prefetches the entry a step would move to.
  assign rd_addr    = (state_q == RUN) ? idx_d : '0;

  pwm_seq_table #(
    .DW    (COUNTER_WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rep_cnt_q    <= '0;
      seq_len_sh_q <= '0;
      repeat_sh_q  <= '0;
      ps_q         <= 1'b1;
      pwm_set_q    <= 1'b1;
      wrap_q       <= 1'b0;
      cmp_q        <= '0;
    end else begin
      ps_q   <= period_start_i;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i) state_q <= START;
        end
        START: begin
          seq_len_sh_q <= seq_len_i;
          repeat_sh_q  <= repeat_i;
          idx_q        <= '0;
          rep_cnt_q    <= '0;
          // Generator holds period_start high while pwm_set is asserted; don't count it.
          ps_q         <= 1'b1;
          cmp_q        <= rd_data;
          pwm_set_q    <= 1'b0;
          state_q      <= RUN;
        end
        RUN: begin
          if (!enable_i) begin
            state_q   <= IDLE;
            pwm_set_q <= 1'b1;
            cmp_q     <= '0;
            idx_q     <= '0;
          end else if (boundary) begin
            if (rep_cnt_q == repeat_sh_q) begin
              rep_cnt_q <= '0;
              idx_q     <= idx_d;
              cmp_q     <= rd_data;
              wrap_q    <= (idx_q == seq_len_sh_q);
            end else begin
              rep_cnt_q <= rep_cnt_q + REPEAT_WIDTH'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmp_value_o = cmp_q;
  assign pwm_set_o   = pwm_set_q;
  assign step_idx_o  = idx_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer with a behavioural 4-bit PWM generator and a period-count reference model.
// Directed vector tables, hand-written corner sequences, then randomized traffic.
module tb_pwm_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       enable;
  logic [1:0] seq_len;
  logic [3:0] repeat_v;
  logic       period_start;
  logic [3:0] cmp_value;
  logic       pwm_set;
  logic [1:0] step_idx;
  logic       wrap;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  pwm_sequencer #(
    .COUNTER_WIDTH (4),
    .DEPTH         (4),
    .REPEAT_WIDTH  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_addr_i      (wr_addr),
    .wr_data_i      (wr_data),
    .enable_i       (enable),
    .seq_len_i      (seq_len),
    .repeat_i       (repeat_v),
    .period_start_i (period_start),
    .cmp_value_o    (cmp_value),
    .pwm_set_o      (pwm_set),
    .step_idx_o     (step_idx),
    .wrap_o         (wrap)
  );

  // PWM generator stand-in: counter held at 0 by pwm_set, period_start while counter is 0.
  logic [3:0] gen_cnt = 4'd0;
  logic       pwm_out;
  always @(posedge clk) begin
    if (pwm_set) gen_cnt <= 4'd0;
    else         gen_cnt <= gen_cnt + 4'd1;
  end
  assign period_start = (gen_cnt == 4'd0);
  assign pwm_out      = !pwm_set && (gen_cnt < cmp_value);

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: counts period boundaries since start; step n selects entry n mod (len+1).
  typedef enum {M_IDLE, M_START, M_RUN} mmode_e;
  mmode_e m_mode = M_IDLE;
  int     m_tab[4];
  int     m_len, m_rep, m_nb, m_cmp, m_idx;
  bit     m_wrap, m_set, m_prev_ps;

  always @(posedge clk) begin
    bit bnd;
    bnd       = period_start && !m_prev_ps;
    m_prev_ps = period_start;
    m_wrap    = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_tab[i] = 0;
      m_mode = M_IDLE; m_cmp = 0; m_idx = 0; m_set = 1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (wr_valid) m_tab[wr_addr] = int'(wr_data);
          if (enable) m_mode = M_START;
        end
        M_START: begin
          m_len = int'(seq_len); m_rep = int'(repeat_v); m_nb = 0;
          m_idx = 0; m_cmp = m_tab[0]; m_set = 0; m_prev_ps = 1;
          m_mode = M_RUN;
        end
        M_RUN: begin
          if (!enable) begin
            m_mode = M_IDLE; m_cmp = 0; m_idx = 0; m_set = 1;
          end else if (bnd) begin
            m_nb++;
            if (m_nb % (m_rep + 1) == 0) begin
              m_idx  = (m_nb / (m_rep + 1)) % (m_len + 1);
              m_cmp  = m_tab[m_idx];
              m_wrap = (m_idx == 0);
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_cmp",   int'(cmp_value), m_cmp);
      chk("model_set",   int'(pwm_set),   int'(m_set));
      chk("model_idx",   int'(step_idx),  m_idx);
      chk("model_wrap",  int'(wrap),      int'(m_wrap));
      chk("model_ready", int'(wr_ready),  int'(m_mode == M_IDLE));
    end
  end

  // k = number of rising edges after enable was raised.
  typedef struct {
    int k;
    int cmp;
    int idx;
    int wrap;
    int set;
  } vec_t;
  vec_t vec[16];

  task automatic play(input int n, input string tag);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      while (k < vec[i].k) begin
        @(posedge clk);
        k++;
      end
      @(negedge clk);
      chk({tag, "_cmp"},  int'(cmp_value), vec[i].cmp);
      chk({tag, "_idx"},  int'(step_idx),  vec[i].idx);
      chk({tag, "_wrap"}, int'(wrap),      vec[i].wrap);
      chk({tag, "_set"},  int'(pwm_set),   vec[i].set);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_valid = 1'b1; wr_addr = 2'(a); wr_data = 4'(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic stop();
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idx(input int target, input int budget, input string name);
    int n = 0;
    while (int'(step_idx) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(int'(step_idx) == target), 1);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    enable = 1'b0; seq_len = '0; repeat_v = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    // 1: reset state and idle
    chk("rst_cmp", int'(cmp_value), 0);
    chk("rst_set", int'(pwm_set), 1);
    chk("rst_ready", int'(wr_ready), 1);
    chk("rst_wrap", int'(wrap), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_pwm_out", int'(pwm_out), 0);
    end

    // 2: four-step sequence, one step per 16-cycle period
    wr(0, 2); wr(1, 8); wr(2, 14); wr(3, 0);
    seq_len = 2'd3; repeat_v = 4'd0; enable = 1'b1;
    vec[0] = '{1, 0, 0, 0, 1};   vec[1] = '{2, 2, 0, 0, 0};
    vec[2] = '{18, 2, 0, 0, 0};  vec[3] = '{19, 8, 1, 0, 0};
    vec[4] = '{35, 14, 2, 0, 0}; vec[5] = '{51, 0, 3, 0, 0};
    vec[6] = '{66, 0, 3, 0, 0};  vec[7] = '{67, 2, 0, 1, 0};
    vec[8] = '{68, 2, 0, 0, 0};  vec[9] = '{83, 8, 1, 0, 0};
    play(10, "seq4");
    stop();

    // 3: repeat=2, two entries, each held three periods
    wr(0, 4); wr(1, 12);
    seq_len = 2'd1; repeat_v = 4'd2; enable = 1'b1;
    vec[0] = '{2, 4, 0, 0, 0};   vec[1] = '{50, 4, 0, 0, 0};
    vec[2] = '{51, 12, 1, 0, 0}; vec[3] = '{98, 12, 1, 0, 0};
    vec[4] = '{99, 4, 0, 1, 0};  vec[5] = '{100, 4, 0, 0, 0};
    play(6, "rep3");

    // 4: write during RUN stalls, lands after stop
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 4'd9;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stall_ready", int'(wr_ready), 0);
    end
    enable = 1'b0;
    @(negedge clk);
    chk("stop_set", int'(pwm_set), 1);
    chk("stop_ready", int'(wr_ready), 1);
    @(negedge clk);
    wr_valid = 1'b0;
    seq_len = 2'd0; repeat_v = 4'd0; enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("pending_write_cmp", int'(cmp_value), 9);
    stop();

    // 5: reset mid-RUN clears table
    wr(0, 2); wr(1, 8); wr(2, 14); wr(3, 0);
    seq_len = 2'd3; repeat_v = 4'd0; enable = 1'b1;
    wait_idx(2, 200, "reach_idx2");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_cmp", int'(cmp_value), 0);
    chk("midrst_set", int'(pwm_set), 1);
    chk("midrst_idx", int'(step_idx), 0);
    chk("midrst_ready", int'(wr_ready), 1);
    vec[0] = '{2, 0, 0, 0, 0}; vec[1] = '{19, 0, 1, 0, 0}; vec[2] = '{35, 0, 2, 0, 0};
    play(3, "cleared");
    stop();

    // 6: seq_len change during RUN ignored until restart
    wr(0, 1); wr(1, 3); wr(2, 5); wr(3, 7);
    seq_len = 2'd3; repeat_v = 4'd0; enable = 1'b1;
    repeat (10) @(negedge clk);
    seq_len = 2'd0;
    wait_idx(3, 100, "shadow_len_reaches3");
    stop();

    // Boundary coinciding with stop: no step, no wrap
    seq_len = 2'd0; repeat_v = 4'd0; enable = 1'b1;
    repeat (20) @(negedge clk);
    for (int n = 0; n < 64 && gen_cnt != 4'd15; n++) @(negedge clk);
    chk("found_cnt15", int'(gen_cnt), 15);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("coincide_wrap", int'(wrap), 0);
    chk("coincide_set", int'(pwm_set), 1);
    chk("coincide_cmp", int'(cmp_value), 0);
    @(negedge clk);

    // Randomized traffic checked by the reference model
    for (int c = 0; c < 3000; c++) begin
      wr_valid = ($urandom_range(0, 9) < 3);
      wr_addr  = 2'($urandom_range(0, 3));
      wr_data  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 99) < 5) begin
        seq_len  = 2'($urandom_range(0, 3));
        repeat_v = 4'($urandom_range(0, 3));
      end
      rst = ($urandom_range(0, 999) < 3);
      @(negedge clk);
    end
    rst = 1'b0; wr_valid = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
